// File: rtl/m68k_dma_arbiter.sv
// 68000 bus arbiter: runs the BR/BG/BGACK handshake on behalf of NREQ on-board DMA
// masters, granting them round-robin and asking the owner to yield after MAX_HOLD cycles.
module m68k_dma_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic            clk16,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] yield,
    output wire             br_n,
    input  logic            bg_n,
    inout  wire             bgack_n,
    input  logic            as_n,
    input  logic            dtack_n
);

    localparam int              OW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              HW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic            YIELD_EN   = (MAX_HOLD != 0);
    localparam logic [HW-1:0]   HOLD_LIMIT = HW'((MAX_HOLD > 0) ? MAX_HOLD : 1);
    localparam logic [OW-1:0]   LAST_IDX   = OW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_BUS,
        OWN,
        REL
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic [OW-1:0]   pick;
    logic [HW-1:0]   hold_cnt;
    logic            yield_sticky;
    logic            yield_now;
    logic            others_req;
    logic [NREQ-1:0] owner_oh;
    logic            br_drive;
    logic            bgack_drive;
    logic            bg_r;
    logic            as_r;
    logic            dtack_r;
    logic            bgack_r;

    // Walk forward from the index after the previous owner, wrapping at NREQ-1.
    always_comb begin : rr_pick
        logic [OW-1:0] cand;
        logic          found;
        cand  = last;
        found = 1'b0;
        pick  = last;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + OW'(1);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign owner_oh   = NREQ'(1) << owner;
    assign others_req = |(req & ~owner_oh);
    assign yield_now  = YIELD_EN && (hold_cnt >= HOLD_LIMIT) && others_req;

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        gnt         = '0;
        yield       = '0;
        br_drive    = 1'b0;
        bgack_drive = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                br_drive = 1'b1;
                if (!req[owner]) begin
                    next_state = IDLE;
                end else if (!bg_r) begin
                    next_state = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                br_drive = 1'b1;
                if (!req[owner]) begin
                    next_state = IDLE;
                end else if (as_r && dtack_r && bgack_r) begin
                    next_state = OWN;
                end
            end
            OWN: begin
                bgack_drive = 1'b1;
                gnt         = owner_oh;
                if (yield_now || yield_sticky) begin
                    yield = owner_oh;
                end
                if (!req[owner]) begin
                    next_state = REL;
                end
            end
            REL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bus-sense inputs come from the 68000 side and are resampled once before use.
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            owner        <= LAST_IDX;
            last         <= LAST_IDX;
            hold_cnt     <= '0;
            yield_sticky <= 1'b0;
            bg_r         <= 1'b1;
            as_r         <= 1'b1;
            dtack_r      <= 1'b1;
            bgack_r      <= 1'b1;
        end else begin
            bg_r    <= bg_n;
            as_r    <= as_n;
            dtack_r <= dtack_n;
            bgack_r <= bgack_n;
            if (state == IDLE && |req) begin
                owner <= pick;
            end
            if (state == REL) begin
                last <= owner;
            end
            if (state == OWN) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                yield_sticky <= yield_sticky | yield_now;
            end else begin
                hold_cnt     <= '0;
                yield_sticky <= 1'b0;
            end
        end
    end

    assign br_n    = br_drive ? 1'b0 : 1'bz;
    assign bgack_n = bgack_drive ? 1'b0 : 1'bz;

    a_gnt_onehot: assert property (@(posedge clk16) disable iff (!reset_n) $onehot0(gnt));
    a_gnt_bgack:  assert property (@(posedge clk16) disable iff (!reset_n) (|gnt) |-> bgack_drive);

endmodule

// File: tb/tb_m68k_dma_arbiter.sv
// Bench for m68k_dma_arbiter: fixed vector table, hand sequences for the bus-busy,
// yield and reset corners, then random traffic against a behavioural model.
module tb_m68k_dma_arbiter;

    localparam int NREQ     = 2;
    localparam int MAX_HOLD = 64;

    localparam int P_IDLE = 0;
    localparam int P_ASK  = 1;
    localparam int P_WAIT = 2;
    localparam int P_OWN  = 3;
    localparam int P_REL  = 4;

    logic            clk16 = 1'b0;
    logic            reset_n;
    logic [NREQ-1:0] req;
    logic            bg_n;
    logic            as_n;
    logic            dtack_n;
    logic            ext_bgack;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] yield;
    logic [NREQ-1:0] gnt_nh;
    logic [NREQ-1:0] yield_nh;
    wire             br_n;
    wire             bgack_n;
    wire             br_n_nh;
    wire             bgack_n_nh;

    pullup (br_n);
    pullup (bgack_n);
    pullup (br_n_nh);
    pullup (bgack_n_nh);
    assign bgack_n    = ext_bgack ? 1'b0 : 1'bz;
    assign bgack_n_nh = ext_bgack ? 1'b0 : 1'bz;

    always #5 clk16 = ~clk16;

    m68k_dma_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) u_dut (
        .clk16   (clk16),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .yield   (yield),
        .br_n    (br_n),
        .bg_n    (bg_n),
        .bgack_n (bgack_n),
        .as_n    (as_n),
        .dtack_n (dtack_n)
    );

    m68k_dma_arbiter #(.NREQ(NREQ), .MAX_HOLD(0)) u_dut_nohold (
        .clk16   (clk16),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt_nh),
        .yield   (yield_nh),
        .br_n    (br_n_nh),
        .bg_n    (bg_n),
        .bgack_n (bgack_n_nh),
        .as_n    (as_n),
        .dtack_n (dtack_n)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Reference model: protocol phase plus one-cycle delayed copies of the bus senses.
    int m_phase   = P_IDLE;
    int m_owner   = 0;
    int m_last    = NREQ - 1;
    int m_hold    = 0;
    bit m_latched = 1'b0;
    bit m_bg_d    = 1'b1;
    bit m_as_d    = 1'b1;
    bit m_dt_d    = 1'b1;
    bit m_bgack_d = 1'b1;

    typedef struct {
        logic            rst_n;
        logic [NREQ-1:0] req;
        logic            bg_n;
        logic [NREQ-1:0] exp_gnt;
        logic            exp_br_n;
        logic            exp_bgack_n;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, got, want);
        end
    endtask

    function automatic int rrChoose(logic [NREQ-1:0] r, int last_i);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last_i + k) % NREQ]) return (last_i + k) % NREQ;
        end
        return last_i;
    endfunction

    function automatic bit othersWaiting();
        logic [NREQ-1:0] mine;
        mine = NREQ'(1) << m_owner;
        return (req & ~mine) != '0;
    endfunction

    task automatic modelStep();
        int nphase;
        bit line;
        line = !((m_phase == P_OWN) || ext_bgack);
        if (!reset_n) begin
            m_phase   = P_IDLE;
            m_last    = NREQ - 1;
            m_hold    = 0;
            m_latched = 1'b0;
            m_bg_d    = 1'b1;
            m_as_d    = 1'b1;
            m_dt_d    = 1'b1;
            m_bgack_d = 1'b1;
            return;
        end
        nphase = m_phase;
        case (m_phase)
            P_IDLE: if (req != '0) begin
                nphase  = P_ASK;
                m_owner = rrChoose(req, m_last);
            end
            P_ASK: begin
                if (!req[m_owner]) nphase = P_IDLE;
                else if (!m_bg_d) nphase = P_WAIT;
            end
            P_WAIT: begin
                if (!req[m_owner]) nphase = P_IDLE;
                else if (m_as_d && m_dt_d && m_bgack_d) nphase = P_OWN;
            end
            P_OWN: begin
                if (MAX_HOLD != 0 && m_hold >= MAX_HOLD && othersWaiting()) m_latched = 1'b1;
                m_hold++;
                if (!req[m_owner]) nphase = P_REL;
            end
            default: begin
                m_last = m_owner;
                nphase = P_IDLE;
            end
        endcase
        if (nphase == P_OWN && m_phase != P_OWN) begin
            m_hold    = 0;
            m_latched = 1'b0;
        end
        m_phase   = nphase;
        m_bg_d    = bg_n;
        m_as_d    = as_n;
        m_dt_d    = dtack_n;
        m_bgack_d = line;
    endtask

    task automatic applyStimulus(logic rst, logic [NREQ-1:0] r, logic bg, logic as_v, logic dt, logic ext);
        reset_n   = rst;
        req       = r;
        bg_n      = bg;
        as_n      = as_v;
        dtack_n   = dt;
        ext_bgack = ext;
    endtask

    task automatic checkOutput(string tag, logic [NREQ-1:0] e_gnt, logic [NREQ-1:0] e_yield,
                               logic e_br, logic e_bgack);
        check({tag, ".gnt"}, 8'(gnt), 8'(e_gnt));
        check({tag, ".yield"}, 8'(yield), 8'(e_yield));
        check({tag, ".br_n"}, 8'(br_n), 8'(e_br));
        check({tag, ".bgack_n"}, 8'(bgack_n), 8'(e_bgack));
    endtask

    task automatic compareModel();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_yield;
        logic            e_br;
        logic            e_bgack;
        e_gnt   = (m_phase == P_OWN) ? NREQ'(1) << m_owner : '0;
        e_yield = '0;
        if (m_phase == P_OWN && MAX_HOLD != 0 && (m_latched || (m_hold >= MAX_HOLD && othersWaiting())))
            e_yield = NREQ'(1) << m_owner;
        e_br    = !(m_phase == P_ASK || m_phase == P_WAIT);
        e_bgack = !(m_phase == P_OWN || ext_bgack);
        checkOutput("model", e_gnt, e_yield, e_br, e_bgack);
        check("nohold.gnt", 8'(gnt_nh), 8'(e_gnt));
        check("nohold.yield", 8'(yield_nh), 8'(0));
        check("nohold.br_n", 8'(br_n_nh), 8'(e_br));
        check("nohold.bgack_n", 8'(bgack_n_nh), 8'(e_bgack));
    endtask

    task automatic tick();
        @(posedge clk16);
        modelStep();
        cycle++;
        #1;
        compareModel();
    endtask

    task automatic addVec(logic rst, logic [NREQ-1:0] r, logic bg, logic [NREQ-1:0] g, logic br, logic bk);
        vec_t v;
        v.rst_n       = rst;
        v.req         = r;
        v.bg_n        = bg;
        v.exp_gnt     = g;
        v.exp_br_n    = br;
        v.exp_bgack_n = bk;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_yield;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Single grant, round-robin after a simultaneous request, and request withdrawn in REQ.
        addVec(0, 2'b00, 1, 2'b00, 1, 1);
        addVec(1, 2'b01, 1, 2'b00, 0, 1);
        addVec(1, 2'b01, 0, 2'b00, 0, 1);
        addVec(1, 2'b01, 0, 2'b00, 0, 1);
        addVec(1, 2'b01, 0, 2'b01, 1, 0);
        addVec(1, 2'b01, 0, 2'b01, 1, 0);
        addVec(1, 2'b00, 0, 2'b00, 1, 1);
        addVec(1, 2'b00, 1, 2'b00, 1, 1);
        addVec(0, 2'b00, 1, 2'b00, 1, 1);
        addVec(1, 2'b11, 0, 2'b00, 0, 1);
        addVec(1, 2'b11, 0, 2'b00, 0, 1);
        addVec(1, 2'b11, 0, 2'b01, 1, 0);
        addVec(1, 2'b10, 0, 2'b00, 1, 1);
        addVec(1, 2'b10, 0, 2'b00, 1, 1);
        addVec(1, 2'b10, 0, 2'b00, 0, 1);
        addVec(1, 2'b10, 0, 2'b00, 0, 1);
        addVec(1, 2'b10, 0, 2'b10, 1, 0);
        addVec(1, 2'b00, 0, 2'b00, 1, 1);
        addVec(1, 2'b00, 1, 2'b00, 1, 1);
        addVec(1, 2'b01, 1, 2'b00, 0, 1);
        addVec(1, 2'b00, 1, 2'b00, 1, 1);
        addVec(1, 2'b00, 1, 2'b00, 1, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].bg_n, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, '0, vecs[i].exp_br_n, vecs[i].exp_bgack_n);
        end

        // Bus stays busy (as_n low) after BG: ownership waits for the resampled strobe.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy.bgack_n", 8'(bgack_n), 8'(1));
            check("busy.gnt", 8'(gnt), 8'(0));
        end
        as_n = 1'b1;
        tick();
        check("busy_release1.gnt", 8'(gnt), 8'(0));
        tick();
        check("busy_release2.gnt", 8'(gnt), 8'(2'b01));
        check("busy_release2.bgack_n", 8'(bgack_n), 8'(0));
        req = '0;
        tick();
        tick();

        // Hold limit: the other requester waits while owner 0 keeps the bus.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check("hold_entry.gnt", 8'(gnt), 8'(2'b01));
        req         = 2'b11;
        first_yield = -1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (yield != '0 && first_yield < 0) first_yield = k;
        end
        check("first_yield_cycle", 8'(first_yield), 8'(MAX_HOLD));
        req = 2'b01;
        tick();
        check("yield_sticky", 8'(yield), 8'(2'b01));
        req = 2'b00;
        tick();
        check("yield_rel", 8'(yield), 8'(0));
        check("yield_rel.gnt", 8'(gnt), 8'(0));
        tick();

        // Reset asserted while a master owns the bus.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check("pre_reset.gnt", 8'(gnt), 8'(2'b01));
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("reset.gnt", 8'(gnt), 8'(0));
        check("reset.br_n", 8'(br_n), 8'(1));
        check("reset.bgack_n", 8'(bgack_n), 8'(0) | 8'(1));
        tick();
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();

        // Random traffic; requesters usually keep their request for a long time.
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0] r;
            r = req;
            for (int b = 0; b < NREQ; b++) begin
                if (!r[b] && ($urandom % 8 == 0)) r[b] = 1'b1;
                else if (r[b] && ($urandom % 80 == 0)) r[b] = 1'b0;
            end
            applyStimulus(($urandom % 700) != 0, r, ($urandom % 4) == 0,
                          ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
